ltl_monitor_sched: RTL and testbench

- Sequencer that feeds a single LTL automaton monitor instance.
- Accepts up to NR_PORTS commit-side symbols per cycle in program order and serialises them into the automaton at one symbol per cycle.
- Drives the automaton's run and reset controls, and latches the first report (property violation) together with the index of the offending symbol.
- Sits between the commit stage and one monitor instance.

---
 rtl/ltl_monitor_sched.sv | 151 +++++++++++++++
 tb/tb_ltl_monitor_sched.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ltl_monitor_sched.sv
// Serialises commit-side symbol bundles into a single LTL automaton monitor,
// sequences the automaton reset, and latches the first reported violation.
module ltl_monitor_sched #(
  parameter int NR_PORTS   = 2,
  parameter int SYM_W      = 8,
  parameter int DEPTH      = 8,
  parameter int NR_REPORT  = 4,
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      enable_i,
  input  logic                      restart_i,
  input  logic [NR_PORTS-1:0]       sym_valid_i,
  input  logic [NR_PORTS*SYM_W-1:0] sym_i,
  output logic                      sym_ready_o,
  output logic                      aut_reset_o,
  output logic                      aut_run_o,
  output logic [SYM_W-1:0]          aut_symbol_o,
  input  logic [NR_REPORT-1:0]      aut_report_i,
  output logic                      violation_o,
  output logic [NR_REPORT-1:0]      violation_id_o,
  output logic [CNT_W-1:0]          violation_idx_o,
  output logic [CNT_W-1:0]          sym_count_o,
  output logic                      busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(RST_CYCLES) + 1;

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_HALT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d, fill_d, push_cnt;
  logic [AW-1:0]   wr_addr [NR_PORTS];
  logic [SYM_W-1:0] mem [DEPTH];
  logic            run_q;
  logic            empty, push, pop, viol_hit;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  // Report belongs to the symbol the automaton consumed last cycle.
  assign viol_hit = run_q && (state_q == ST_RUN) && (|aut_report_i) && !restart_i;
  assign push     = sym_ready_o && (|sym_valid_i) && (state_q != ST_HALT) && !restart_i;
  assign pop      = (state_q == ST_RUN) && enable_i && !empty && !viol_hit && !restart_i;

  // Compact valid ports into consecutive FIFO slots, oldest port first.
  always_comb begin
    // NOTE: blocking assignments here build a running sum within one evaluation;
    // the sequential blocks below use non-blocking so all registers update together.
    push_cnt = '0;
    for (int k = 0; k < NR_PORTS; k++) begin
      wr_addr[k] = wr_ptr_q[AW-1:0] + push_cnt[AW-1:0];
      if (sym_valid_i[k]) push_cnt = push_cnt + PW'(1);
    end
  end

  // Next pointers, fill level and FSM transitions.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    wr_ptr_d  = wr_ptr_q + (push ? push_cnt : '0);
    rd_ptr_d  = rd_ptr_q + (pop ? PW'(1) : '0);
    if (restart_i) begin
      state_d   = ST_INIT;
      rst_cnt_d = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
    end else begin
      unique case (state_q)
        ST_INIT: begin
          if (rst_cnt_q == CW'(RST_CYCLES - 1)) state_d = ST_RUN;
          else                                  rst_cnt_d = rst_cnt_q + CW'(1);
        end
        ST_RUN:  if (viol_hit) state_d = ST_HALT;
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_INIT;
      endcase
    end
    fill_d = wr_ptr_d - rd_ptr_d;
  end

  // FSM state, reset counter and FIFO pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_INIT;
      rst_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // FIFO storage write.
  // NOTE: the storage array has no reset; pointers alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) begin
      for (int k = 0; k < NR_PORTS; k++) begin
        if (sym_valid_i[k]) mem[wr_addr[k]] <= sym_i[k*SYM_W +: SYM_W];
      end
    end
  end

  // Registered outputs: automaton controls, flow control, count and violation capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aut_reset_o     <= 1'b1;
      aut_run_o       <= 1'b0;
      aut_symbol_o    <= '0;
      sym_ready_o     <= 1'b0;
      run_q           <= 1'b0;
      violation_o     <= 1'b0;
      violation_id_o  <= '0;
      violation_idx_o <= '0;
      sym_count_o     <= '0;
      busy_o          <= 1'b1;
    end else if (restart_i) begin
      aut_reset_o     <= 1'b1;
      aut_run_o       <= 1'b0;
      sym_ready_o     <= 1'b0;
      run_q           <= 1'b0;
      violation_o     <= 1'b0;
      violation_id_o  <= '0;
      violation_idx_o <= '0;
      sym_count_o     <= '0;
      busy_o          <= 1'b1;
    end else begin
      aut_reset_o <= (state_d == ST_INIT);
      aut_run_o   <= pop;
      if (pop) aut_symbol_o <= mem[rd_ptr_q[AW-1:0]];
      run_q       <= aut_run_o;
      if (aut_run_o && !(&sym_count_o)) sym_count_o <= sym_count_o + CNT_W'(1);
      if (viol_hit) begin
        violation_o     <= 1'b1;
        violation_id_o  <= aut_report_i;
        violation_idx_o <= sym_count_o - CNT_W'(1);
      end
      sym_ready_o <= (state_d == ST_HALT) || (fill_d <= PW'(DEPTH - NR_PORTS));
      busy_o      <= (fill_d != '0) || (state_d == ST_INIT);
    end
  end

endmodule

// File: tb/tb_ltl_monitor_sched.sv
// Self-checking bench for ltl_monitor_sched: directed vector table, hand-written
// violation/restart sequences, then random traffic against a queue-based model.
module tb_ltl_monitor_sched;

  localparam int NR_PORTS = 2;
  localparam int SYM_W    = 8;
  localparam int DEPTH    = 8;
  localparam int NR_REP   = 4;
  localparam int RST_CYC  = 2;
  localparam int CNT_W    = 32;

  localparam int M_INIT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      enable, restart;
  logic [NR_PORTS-1:0]       valid;
  logic [NR_PORTS*SYM_W-1:0] sym;
  logic [NR_REP-1:0]         report;
  logic                      sym_ready, aut_reset, aut_run, violation, busy;
  logic [SYM_W-1:0]          aut_symbol;
  logic [NR_REP-1:0]         violation_id;
  logic [CNT_W-1:0]          violation_idx, sym_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ltl_monitor_sched #(
    .NR_PORTS(NR_PORTS), .SYM_W(SYM_W), .DEPTH(DEPTH),
    .NR_REPORT(NR_REP), .RST_CYCLES(RST_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .restart_i(restart),
    .sym_valid_i(valid), .sym_i(sym), .sym_ready_o(sym_ready),
    .aut_reset_o(aut_reset), .aut_run_o(aut_run), .aut_symbol_o(aut_symbol),
    .aut_report_i(report), .violation_o(violation), .violation_id_o(violation_id),
    .violation_idx_o(violation_idx), .sym_count_o(sym_count), .busy_o(busy)
  );

  // Reference model: symbols waiting for the automaton kept as a plain queue.
  logic [SYM_W-1:0] q [$];
  int               m_state, m_rcnt;
  logic             m_reset, m_run, m_ready, m_viol, m_busy, m_runq;
  logic [SYM_W-1:0] m_sym;
  logic [NR_REP-1:0] m_id;
  logic [CNT_W-1:0] m_idx, m_count;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_state = M_INIT; m_rcnt = 0;
    m_reset = 1'b1; m_run = 1'b0; m_sym = '0; m_ready = 1'b0; m_runq = 1'b0;
    m_viol = 1'b0; m_id = '0; m_idx = '0; m_count = '0; m_busy = 1'b1;
  endtask

  // Advance the model by one clock using the inputs held during that cycle.
  task automatic model_step();
    logic hit, acc, do_pop, prev_run;
    if (restart) begin
      q.delete();
      m_state = M_INIT; m_rcnt = 0;
      m_reset = 1'b1; m_run = 1'b0; m_runq = 1'b0; m_ready = 1'b0;
      m_viol = 1'b0; m_id = '0; m_idx = '0; m_count = '0; m_busy = 1'b1;
      return;
    end
    hit      = m_runq && (m_state == M_RUN) && (report != 0);
    acc      = m_ready && (valid != 0) && (m_state != M_HALT);
    do_pop   = (m_state == M_RUN) && enable && (q.size() > 0) && !hit;
    prev_run = m_run;
    if (hit) begin
      m_viol = 1'b1; m_id = report; m_idx = m_count - 1;
    end
    if (m_run && m_count != {CNT_W{1'b1}}) m_count = m_count + 1;
    if (do_pop) begin
      m_sym = q.pop_front(); m_run = 1'b1;
    end else begin
      m_run = 1'b0;
    end
    if (acc)
      for (int k = 0; k < NR_PORTS; k++)
        if (valid[k]) q.push_back(sym[k*SYM_W +: SYM_W]);
    m_runq = prev_run;
    if (m_state == M_INIT) begin
      if (m_rcnt == RST_CYC - 1) m_state = M_RUN;
      else m_rcnt++;
    end else if (m_state == M_RUN && hit) begin
      m_state = M_HALT;
    end
    m_reset = (m_state == M_INIT);
    m_ready = (m_state == M_HALT) || ((DEPTH - q.size()) >= NR_PORTS);
    m_busy  = (q.size() > 0) || (m_state == M_INIT);
  endtask

  task automatic compare_all();
    check("aut_reset", aut_reset, m_reset);
    check("aut_run", aut_run, m_run);
    check("aut_symbol", aut_symbol, m_sym);
    check("sym_ready", sym_ready, m_ready);
    check("violation", violation, m_viol);
    check("violation_id", violation_id, m_id);
    check("violation_idx", violation_idx, m_idx);
    check("sym_count", sym_count, m_count);
    check("busy", busy, m_busy);
  endtask

  // One clock: inputs are already applied; model follows, outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic r, input logic e, input logic [1:0] v,
                       input logic [7:0] p0, input logic [7:0] p1, input logic [3:0] rep);
    restart = r; enable = e; valid = v; sym = {p1, p0}; report = rep;
  endtask

  typedef struct {
    logic        en;
    logic [1:0]  v;
    logic [7:0]  p0, p1;
    logic        e_reset, e_run;
    logic [7:0]  e_sym;
    logic        e_ready;
    int          e_count;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(input logic en, input logic [1:0] v, input logic [7:0] p0,
                              input logic [7:0] p1, input logic er, input logic eu,
                              input logic [7:0] es, input logic ey, input int ec);
    vec_t t;
    t.en = en; t.v = v; t.p0 = p0; t.p1 = p1;
    t.e_reset = er; t.e_run = eu; t.e_sym = es; t.e_ready = ey; t.e_count = ec;
    return t;
  endfunction

  initial begin
    //            en  v      p0     p1     rst  run  sym    rdy  cnt
    tbl[0]  = mk(1, 2'b00, 8'h00, 8'h00, 1, 0, 8'h00, 1, 0);
    tbl[1]  = mk(1, 2'b00, 8'h00, 8'h00, 0, 0, 8'h00, 1, 0);
    tbl[2]  = mk(1, 2'b11, 8'h10, 8'h50, 0, 0, 8'h00, 1, 0);
    tbl[3]  = mk(1, 2'b00, 8'h00, 8'h00, 0, 1, 8'h10, 1, 0);
    tbl[4]  = mk(1, 2'b00, 8'h00, 8'h00, 0, 1, 8'h50, 1, 1);
    tbl[5]  = mk(1, 2'b10, 8'hAA, 8'hC0, 0, 0, 8'h50, 1, 2);
    tbl[6]  = mk(1, 2'b00, 8'h00, 8'h00, 0, 1, 8'hC0, 1, 2);
    tbl[7]  = mk(1, 2'b00, 8'h00, 8'h00, 0, 0, 8'hC0, 1, 3);
    tbl[8]  = mk(0, 2'b11, 8'h11, 8'h22, 0, 0, 8'hC0, 1, 3);
    tbl[9]  = mk(0, 2'b11, 8'h33, 8'h44, 0, 0, 8'hC0, 1, 3);
    tbl[10] = mk(0, 2'b11, 8'h55, 8'h66, 0, 0, 8'hC0, 1, 3);
    tbl[11] = mk(0, 2'b11, 8'h77, 8'h88, 0, 0, 8'hC0, 0, 3);
    tbl[12] = mk(0, 2'b11, 8'h99, 8'hAA, 0, 0, 8'hC0, 0, 3);
    tbl[13] = mk(1, 2'b00, 8'h00, 8'h00, 0, 1, 8'h11, 0, 3);
    tbl[14] = mk(1, 2'b00, 8'h00, 8'h00, 0, 1, 8'h22, 1, 4);
    tbl[15] = mk(1, 2'b00, 8'h00, 8'h00, 0, 1, 8'h33, 1, 5);
    tbl[16] = mk(1, 2'b00, 8'h00, 8'h00, 0, 1, 8'h44, 1, 6);
    tbl[17] = mk(1, 2'b00, 8'h00, 8'h00, 0, 1, 8'h55, 1, 7);
    tbl[18] = mk(1, 2'b00, 8'h00, 8'h00, 0, 1, 8'h66, 1, 8);
    tbl[19] = mk(1, 2'b00, 8'h00, 8'h00, 0, 1, 8'h77, 1, 9);
    tbl[20] = mk(1, 2'b00, 8'h00, 8'h00, 0, 1, 8'h88, 1, 10);
    tbl[21] = mk(1, 2'b00, 8'h00, 8'h00, 0, 0, 8'h88, 1, 11);

    // Reset state.
    rst_n = 1'b0;
    drive(0, 1, 2'b00, 8'h00, 8'h00, 4'h0);
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;

    // Directed table: init, bundle push, hole skipping, back-pressure, drain.
    for (int i = 0; i < 22; i++) begin
      drive(0, tbl[i].en, tbl[i].v, tbl[i].p0, tbl[i].p1, 4'h0);
      tick();
      check($sformatf("tbl%0d_reset", i), aut_reset, tbl[i].e_reset);
      check($sformatf("tbl%0d_run", i), aut_run, tbl[i].e_run);
      check($sformatf("tbl%0d_sym", i), aut_symbol, tbl[i].e_sym);
      check($sformatf("tbl%0d_ready", i), sym_ready, tbl[i].e_ready);
      check($sformatf("tbl%0d_count", i), sym_count, CNT_W'(tbl[i].e_count));
    end

    // Violation on the 12th issued symbol (index 11).
    drive(0, 1, 2'b01, 8'hD0, 8'hD1, 4'h0); tick();
    drive(0, 1, 2'b00, 8'h00, 8'h00, 4'h0); tick();
    check("viol_issue_run", aut_run, 1'b1);
    check("viol_issue_sym", aut_symbol, 8'hD0);
    tick();
    drive(0, 1, 2'b00, 8'h00, 8'h00, 4'b0100); tick();
    check("viol_flag", violation, 1'b1);
    check("viol_id", violation_id, 4'b0100);
    check("viol_idx", violation_idx, 11);
    check("viol_run", aut_run, 1'b0);
    check("viol_ready", sym_ready, 1'b1);

    // HALT: bundles discarded, later reports ignored, fields frozen.
    drive(0, 1, 2'b11, 8'hF0, 8'hF1, 4'b0010); tick();
    drive(0, 1, 2'b11, 8'hF2, 8'hF3, 4'b1000); tick();
    check("halt_ready", sym_ready, 1'b1);
    check("halt_run", aut_run, 1'b0);
    check("halt_id", violation_id, 4'b0100);
    check("halt_busy", busy, 1'b0);

    // Restart coinciding with a push and a report.
    drive(1, 1, 2'b11, 8'hE0, 8'hE1, 4'b0001); tick();
    check("rst_viol", violation, 1'b0);
    check("rst_count", sym_count, 0);
    check("rst_reset", aut_reset, 1'b1);
    check("rst_ready", sym_ready, 1'b0);
    drive(0, 1, 2'b00, 8'h00, 8'h00, 4'h0); tick();
    check("rst_hold1", aut_reset, 1'b1);
    tick();
    check("rst_hold2", aut_reset, 1'b0);
    check("rst_busy", busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_no_issue", aut_run, 1'b0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
            ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'h0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
